sr_latch_driver: RTL and testbench

- Clocked front end for the binary NOR set/reset latch cell.
- Converts a one-bit write request into a single non-overlapping set or reset pulse on the latch's S/R inputs.
- After a settle interval, reads back the latch's complementary outputs and retries on mismatch. Reports a pass/fail response upstream.
- Sits between a synchronous controller and the asynchronous latch; the S/R pair maps to the latch's io_in[0]/io_in[1] and Q/QN to its io_out[1:0].

---
 rtl/sr_latch_pkg.sv | 21 ++
 rtl/sr_phase_timer.sv | 34 +++
 rtl/sr_latch_driver.sv | 175 +++++++++++++++++
 tb/tb_sr_latch_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and constants for the NOR set/reset latch driver.
// Bit positions map the S/R/Q/QN pins onto the latch cell's io_in/io_out buses.
package sr_latch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StResp
    } state_e;

    localparam int unsigned TriesWidth = 3;
    localparam int unsigned TimerWidth = 4;

    localparam int unsigned IoS  = 0;
    localparam int unsigned IoR  = 1;
    localparam int unsigned IoQ  = 0;
    localparam int unsigned IoQn = 1;

endpackage

// File: rtl/sr_phase_timer.sv
// Down-counter shared by the DRIVE and SETTLE phases.
// load_val is the phase length minus one; done is high while the count sits at zero.
module sr_phase_timer
    import sr_latch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [TimerWidth-1:0] load_val,
    output logic                  done
);

    logic [TimerWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TimerWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked front end for the NOR S/R latch: issues one set or reset pulse per request,
// waits for the latch to settle, checks the synchronised Q/QN readback and retries on mismatch.
module sr_latch_driver
    import sr_latch_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_RETRY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_data,
    output logic                  latch_s,
    output logic                  latch_r,
    input  logic                  latch_q,
    input  logic                  latch_qn,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_ok,
    output logic                  rsp_q,
    output logic [TriesWidth-1:0] rsp_tries
);

    localparam logic [TimerWidth-1:0] PulseLoad  = TimerWidth'(PULSE_CYCLES - 1);
    localparam logic [TimerWidth-1:0] SettleLoad = TimerWidth'(SETTLE_CYCLES - 1);
    localparam logic [TriesWidth:0]   MaxRetry   = (TriesWidth + 1)'(MAX_RETRY);

    state_e                state_q, state_d;
    logic                  data_q, data_d;
    logic [TriesWidth-1:0] tries_q, tries_d;
    logic [1:0]            drv_q, drv_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_ok_q, rsp_ok_d;
    logic                  rsp_q_q, rsp_q_d;
    logic [TriesWidth-1:0] rsp_tries_q, rsp_tries_d;

    logic [1:0]            io_out;
    logic [1:0]            sync_meta_q, sync_q;
    logic                  accept;
    logic                  pass;
    logic                  tmr_load;
    logic [TimerWidth-1:0] tmr_val;
    logic                  tmr_done;

    assign io_out[IoQ]  = latch_q;
    assign io_out[IoQn] = latch_qn;

    // Latch outputs are asynchronous to clk; two flops before they reach the compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= io_out;
            sync_q      <= sync_meta_q;
        end
    end

    // Q==QN (including the both-low forbidden output) never matches a complementary pair.
    assign pass = (sync_q[IoQ] == data_q) && (sync_q[IoQn] == ~data_q);

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    sr_phase_timer u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        tries_d     = tries_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_q_d     = rsp_q_q;
        rsp_tries_d = rsp_tries_q;
        tmr_load    = 1'b0;
        tmr_val     = PulseLoad;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d   = req_data;
                    tries_d  = TriesWidth'(1);
                    state_d  = StDrive;
                    tmr_load = 1'b1;
                    tmr_val  = PulseLoad;
                end
            end
            StDrive: begin
                if (tmr_done) begin
                    state_d  = StSettle;
                    tmr_load = 1'b1;
                    tmr_val  = SettleLoad;
                end
            end
            StSettle: begin
                if (tmr_done) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (pass) begin
                    state_d     = StResp;
                    rsp_ok_d    = 1'b1;
                    rsp_q_d     = sync_q[IoQ];
                    rsp_tries_d = tries_q;
                end else if ({1'b0, tries_q} <= MaxRetry) begin
                    tries_d  = tries_q + TriesWidth'(1);
                    state_d  = StDrive;
                    tmr_load = 1'b1;
                    tmr_val  = PulseLoad;
                end else begin
                    state_d     = StResp;
                    rsp_ok_d    = 1'b0;
                    rsp_q_d     = sync_q[IoQ];
                    rsp_tries_d = tries_q;
                end
            end
            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Drive pins follow the registered state one edge later, so S and R can never overlap.
    always_comb begin
        drv_d = '0;
        if (state_q == StDrive) begin
            drv_d[IoS] = data_q;
            drv_d[IoR] = ~data_q;
        end
        rsp_valid_d = (state_q == StResp) && !(rsp_valid_q && rsp_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= 1'b0;
            tries_q     <= '0;
            drv_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_q_q     <= 1'b0;
            rsp_tries_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            tries_q     <= tries_d;
            drv_q       <= drv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_q_q     <= rsp_q_d;
            rsp_tries_q <= rsp_tries_d;
        end
    end

    assign latch_s   = drv_q[IoS];
    assign latch_r   = drv_q[IoR];
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_tries = rsp_tries_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with a behavioural NOR latch that can be
// stuck or forced into the both-low output; expectations come from a per-try readback model.
module tb_sr_latch_driver;

    localparam int P = 2;
    localparam int S = 2;
    localparam int M = 2;

    typedef struct {
        bit ok;
        bit q;
        int tries;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_data;
    logic       latch_s;
    logic       latch_r;
    logic       latch_q;
    logic       latch_qn;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_ok;
    logic       rsp_q;
    logic [2:0] rsp_tries;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   acc_id = 0;
    int   npulse = 0;
    bit   cur_data = 1'b0;
    bit   lat = 1'b0;
    bit   stuck = 1'b0;
    bit   force0 = 1'b0;
    exp_t exp_q[$];

    sr_latch_driver #(
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .MAX_RETRY     (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .latch_s   (latch_s),
        .latch_r   (latch_r),
        .latch_q   (latch_q),
        .latch_qn  (latch_qn),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ok    (rsp_ok),
        .rsp_q     (rsp_q),
        .rsp_tries (rsp_tries)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // NOR latch cell; stuck and force0 override what the pins show.
    initial forever begin
        @(latch_s or latch_r);
        if (latch_s === 1'b1 && latch_r === 1'b0) lat = 1'b1;
        else if (latch_r === 1'b1 && latch_s === 1'b0) lat = 1'b0;
    end
    assign latch_q  = stuck ? 1'b0 : (force0 ? 1'b0 : lat);
    assign latch_qn = stuck ? 1'b1 : (force0 ? 1'b0 : ~lat);

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // mode 0: healthy latch, 1: stuck Q=0/QN=1, 2: both-low readback on the first try only
    function automatic exp_t model(input bit d, input int mode);
        exp_t r;
        bit   q, qn;
        for (int t = 1; t <= M + 1; t++) begin
            if (mode == 1) begin
                q = 1'b0; qn = 1'b1;
            end else if (mode == 2 && t == 1) begin
                q = 1'b0; qn = 1'b0;
            end else begin
                q = d; qn = !d;
            end
            r.q = q;
            r.tries = t;
            r.ok = (q == d) && (qn == !d);
            if (r.ok) return r;
        end
        return r;
    endfunction

    task automatic send(input bit d, input int mode);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = d;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", int'(req_ready), 1);
        e        = model(d, mode);
        acc_cyc  = cyc + 1;
        e.lat    = acc_cyc + e.tries * (P + S + 1) + 1;
        cur_data = d;
        exp_q.push_back(e);
        acc_id++;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            if (force0 && npulse >= 2) force0 = 1'b0;
        end
        chk("rsp_timeout", exp_q.size(), 0);
        exp_q.delete();
        rsp_ready = 1'b1;
        stuck     = 1'b0;
        force0    = 1'b0;
    endtask

    // Response monitor: latency at the rising edge of rsp_valid, stability while stalled,
    // field values at the handshake.
    initial begin : rsp_mon
        bit prev_v = 1'b0;
        bit prev_hs = 1'b0;
        bit h_ok = 1'b0;
        bit h_q = 1'b0;
        int h_t = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (rsp_valid && prev_hs) begin
                    chk("rsp_drop_after_hs", int'(rsp_valid), 0);
                end else if (rsp_valid && !prev_v) begin
                    if (exp_q.size() == 0) chk("rsp_unexpected", int'(rsp_valid), 0);
                    else chk("rsp_latency", cyc, exp_q[0].lat);
                    h_ok = rsp_ok;
                    h_q  = rsp_q;
                    h_t  = int'(rsp_tries);
                end else if (rsp_valid) begin
                    chk("rsp_ok_stable", int'(rsp_ok), int'(h_ok));
                    chk("rsp_q_stable", int'(rsp_q), int'(h_q));
                    chk("rsp_tries_stable", int'(rsp_tries), h_t);
                end
                prev_hs = rsp_valid && rsp_ready;
                if (prev_hs && exp_q.size() != 0) begin
                    chk("rsp_ok", int'(rsp_ok), int'(exp_q[0].ok));
                    chk("rsp_q", int'(rsp_q), int'(exp_q[0].q));
                    chk("rsp_tries", int'(rsp_tries), exp_q[0].tries);
                    void'(exp_q.pop_front());
                end
                prev_v = rsp_valid;
            end
        end
    end

    // Pulse monitor: polarity, width, first-pulse start and gap between retries.
    initial begin : pulse_mon
        bit in_pulse = 1'b0;
        int start_cyc = 0;
        int end_cyc = 0;
        int seen_id = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pulse = 1'b0;
            end else begin
                chk("s_and_r_overlap", int'(latch_s && latch_r), 0);
                if (acc_id != seen_id) begin
                    seen_id = acc_id;
                    npulse  = 0;
                end
                if ((latch_s || latch_r) && !in_pulse) begin
                    in_pulse  = 1'b1;
                    start_cyc = cyc;
                    npulse++;
                    chk("pulse_polarity", int'(latch_s), int'(cur_data));
                    if (npulse == 1) chk("pulse_start", cyc - acc_cyc, 1);
                    else chk("pulse_gap_ok", int'(cyc - end_cyc >= S + 1), 1);
                end else if (!(latch_s || latch_r) && in_pulse) begin
                    in_pulse = 1'b0;
                    end_cyc  = cyc;
                    chk("pulse_width", cyc - start_cyc, P);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_latch_s", int'(latch_s), 0);
        chk("rst_latch_r", int'(latch_r), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_ok", int'(rsp_ok), 0);
        chk("rst_rsp_q", int'(rsp_q), 0);
        chk("rst_rsp_tries", int'(rsp_tries), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Healthy set then reset.
        send(1'b1, 0);
        wait_done(1'b0);
        send(1'b0, 0);
        wait_done(1'b0);

        // Stuck latch: every try fails.
        stuck = 1'b1;
        send(1'b1, 1);
        wait_done(1'b0);

        // Both-low readback on the first check forces one retry.
        force0 = 1'b1;
        send(1'b1, 2);
        wait_done(1'b0);

        // Response stalled for 5 cycles with a competing request held upstream.
        rsp_ready = 1'b0;
        send(1'b0, 0);
        for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", int'(req_ready), 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done(1'b0);
        @(negedge clk);
        chk("post_hs_req_ready", int'(req_ready), 1);
        chk("post_hs_rsp_valid", int'(rsp_valid), 0);

        // Reset on the second DRIVE cycle drops the transaction.
        send(1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pulse_before", int'(latch_s), 1);
        @(negedge clk);
        chk("mid_rst_latch_s", int'(latch_s), 0);
        chk("mid_rst_latch_r", int'(latch_r), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("dropped_no_rsp", int'(rsp_valid), 0);
        end
        send(1'b1, 0);
        wait_done(1'b0);

        // Randomised traffic with random upstream backpressure.
        for (int i = 0; i < 24; i++) begin
            int  mode;
            bit  d;
            mode = int'($urandom_range(0, 2));
            d    = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            stuck  = (mode == 1);
            force0 = (mode == 2);
            send(d, mode);
            wait_done(1'b1);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
